// File: rtl/pc_predictor_pkg.sv
// Shared constants, types and decode helpers for the next-PC predictor.
// Imported by the interface, the BHT and the top.
package pc_predictor_pkg;

    localparam int unsigned DataLen = 32;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [1:0] {
        SelHold,
        SelTruePc,
        SelTarget,
        SelSeq
    } next_sel_e;

    function automatic logic signed [DataLen-1:0] j_imm(input logic [DataLen-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic signed [DataLen-1:0] b_imm(input logic [DataLen-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // 2-bit saturating counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/pc_predictor_if.sv
// Fetcher and ROB facing signals of the next-PC predictor.
// master = fetcher/ROB side, slave = predictor side.
interface pc_predictor_if #(
    parameter int unsigned ADDR_W = 32
);
    import pc_predictor_pkg::*;

    logic                has_ask;
    logic [DataLen-1:0]  inst;
    logic [ADDR_W-1:0]   out_next_pc;
    logic                pc_ready;
    logic                has_jump;
    logic                has_misbranch;
    logic [ADDR_W-1:0]   in_true_pc;
    logic                upd_valid;
    logic [ADDR_W-1:0]   upd_pc;
    logic                upd_taken;

    modport master (
        output has_ask, inst, has_misbranch, in_true_pc, upd_valid, upd_pc, upd_taken,
        input  out_next_pc, pc_ready, has_jump
    );

    modport slave (
        input  has_ask, inst, has_misbranch, in_true_pc, upd_valid, upd_pc, upd_taken,
        output out_next_pc, pc_ready, has_jump
    );

endinterface

// File: rtl/pc_predictor_bht.sv
// Bimodal history table: 2-bit saturating counters, combinational read,
// synchronous saturating update, asynchronous reset to CNT_INIT.
module pc_predictor_bht
    import pc_predictor_pkg::*;
#(
    parameter int unsigned IDX_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int unsigned Entries = 1 << IDX_W;

    logic [1:0] ctr_q [Entries];

    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Entries; i++) begin
                ctr_q[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/pc_predictor.sv
// Next-PC generator: JAL always redirected, conditional branches predicted by
// a bimodal BHT trained at commit, ROB misbranch overrides everything.
module pc_predictor
    import pc_predictor_pkg::*;
#(
    parameter int unsigned     ADDR_W    = 32,
    parameter int unsigned     BHT_IDX_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [1:0]      CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    pc_predictor_if.slave   bus
);

    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic                      ready_q, ready_d;
    logic                      jump_q, jump_d;
    logic [1:0]                bht_ctr;
    next_sel_e                 sel;
    logic signed [DataLen-1:0] imm;
    logic [ADDR_W-1:0]         imm_ext;
    logic                      unused_upd_pc;

    assign unused_upd_pc = ^{bus.upd_pc[ADDR_W-1:BHT_IDX_W+2], bus.upd_pc[1:0]};

    pc_predictor_bht #(
        .IDX_W    (BHT_IDX_W),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_q[BHT_IDX_W+1:2]),
        .rd_ctr   (bht_ctr),
        .wr_en    (rdy & bus.upd_valid),
        .wr_idx   (bus.upd_pc[BHT_IDX_W+1:2]),
        .wr_taken (bus.upd_taken)
    );

    always_comb begin
        sel = SelHold;
        imm = '0;
        if (bus.has_misbranch) begin
            sel = SelTruePc;
        end else if (bus.has_ask) begin
            case (bus.inst[6:0])
                OpJal: begin
                    sel = SelTarget;
                    imm = j_imm(bus.inst);
                end
                OpBranch: begin
                    imm = b_imm(bus.inst);
                    sel = bht_ctr[1] ? SelTarget : SelSeq;
                end
                // JALR target is resolved by the ROB; fall through sequentially.
                OpJalr:  sel = SelSeq;
                default: sel = SelSeq;
            endcase
        end
    end

    // Size cast of a signed value sign-extends (or truncates) to ADDR_W.
    assign imm_ext = ADDR_W'(imm);

    always_comb begin
        pc_d    = pc_q;
        ready_d = 1'b1;
        jump_d  = 1'b0;
        unique case (sel)
            SelHold: begin
                ready_d = 1'b0;
                jump_d  = jump_q;
            end
            SelTruePc: pc_d = bus.in_true_pc;
            SelTarget: begin
                pc_d   = pc_q + imm_ext;
                jump_d = 1'b1;
            end
            SelSeq:  pc_d = pc_q + ADDR_W'(4);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            ready_q <= 1'b0;
            jump_q  <= 1'b0;
        end else if (rdy) begin
            pc_q    <= pc_d;
            ready_q <= ready_d;
            jump_q  <= jump_d;
        end
    end

    assign bus.out_next_pc = pc_q;
    assign bus.pc_ready    = ready_q;
    assign bus.has_jump    = jump_q;

endmodule

// File: tb/tb_pc_predictor.sv
// Directed self-checking bench for pc_predictor.
module tb_pc_predictor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    localparam logic [31:0] JalP16  = 32'h0100_006F;
    localparam logic [31:0] JalM4   = 32'hFFDF_F06F;
    localparam logic [31:0] BeqP8   = 32'h0000_0463;
    localparam logic [31:0] BeqM8   = 32'hFE00_0CE3;
    localparam logic [31:0] Addi    = 32'h0000_0013;
    localparam logic [31:0] JalrRet = 32'h0000_8067;

    pc_predictor_if #(.ADDR_W(32)) bus ();

    pc_predictor #(
        .ADDR_W    (32),
        .BHT_IDX_W (8),
        .RESET_PC  (32'h0),
        .CNT_INIT  (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic rdy_exp,
                             input logic jmp);
        check({tag, ".pc"}, bus.out_next_pc, pc);
        check({tag, ".ready"}, {31'b0, bus.pc_ready}, {31'b0, rdy_exp});
        check({tag, ".jump"}, {31'b0, bus.has_jump}, {31'b0, jmp});
    endtask

    function automatic logic [1:0] ctr_at(input logic [31:0] pc);
        return dut.u_bht.ctr_q[pc[9:2]];
    endfunction

    task automatic clear_in();
        bus.has_ask       = 1'b0;
        bus.inst          = '0;
        bus.has_misbranch = 1'b0;
        bus.in_true_pc    = '0;
        bus.upd_valid     = 1'b0;
        bus.upd_pc        = '0;
        bus.upd_taken     = 1'b0;
    endtask

    // Drive one cycle of inputs, step past the edge, then release.
    task automatic cycle(input logic ask, input logic [31:0] ins, input logic misb,
                         input logic [31:0] tpc, input logic uv, input logic [31:0] upc,
                         input logic ut);
        bus.has_ask       = ask;
        bus.inst          = ins;
        bus.has_misbranch = misb;
        bus.in_true_pc    = tpc;
        bus.upd_valid     = uv;
        bus.upd_pc        = upc;
        bus.upd_taken     = ut;
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic ask(input logic [31:0] ins);
        cycle(1'b1, ins, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic misb(input logic [31:0] pc);
        cycle(1'b0, 32'h0, 1'b1, pc, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic train(input logic [31:0] pc, input logic taken);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, taken);
    endtask

    initial begin
        int bad_ctr;
        clear_in();

        // T1 reset
        repeat (3) @(posedge clk);
        #1;
        check_out("t1_reset", 32'h0, 1'b0, 1'b0);
        bad_ctr = 0;
        for (int i = 0; i < 256; i++) begin
            if (dut.u_bht.ctr_q[i] !== 2'b01) bad_ctr++;
        end
        check("t1_bht_init_bad_count", bad_ctr, 0);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_out("t1_idle", 32'h0, 1'b0, 1'b0);

        // T2 JAL
        ask(JalP16);
        check_out("t2_jal", 32'h10, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_out("t2_hold", 32'h10, 1'b0, 1'b1);

        // T3 cold branch, train, re-ask
        ask(BeqP8);
        check_out("t3_cold", 32'h14, 1'b1, 1'b0);
        train(32'h10, 1'b1);
        train(32'h10, 1'b1);
        check("t3_ctr", ctr_at(32'h10), 2'b11);
        misb(32'h10);
        check_out("t3_misb", 32'h10, 1'b1, 1'b0);
        ask(BeqP8);
        check_out("t3_warm", 32'h18, 1'b1, 1'b1);
        misb(32'h10);
        ask(BeqM8);
        check_out("t3_back", 32'h08, 1'b1, 1'b1);
        ask(Addi);
        check_out("t3_addi", 32'h0C, 1'b1, 1'b0);
        ask(JalrRet);
        check_out("t3_jalr", 32'h10, 1'b1, 1'b0);
        misb(32'h0);
        ask(JalM4);
        check_out("t3_wrap", 32'hFFFF_FFFC, 1'b1, 1'b1);

        // T4 saturation
        repeat (5) train(32'h40, 1'b1);
        check("t4_sat_hi", ctr_at(32'h40), 2'b11);
        train(32'h40, 1'b0);
        check("t4_after_nt", ctr_at(32'h40), 2'b10);
        misb(32'h40);
        ask(BeqP8);
        check_out("t4_pred", 32'h48, 1'b1, 1'b1);
        train(32'h40, 1'b1);
        repeat (3) train(32'h40, 1'b0);
        check("t4_down", ctr_at(32'h40), 2'b00);
        train(32'h40, 1'b0);
        check("t4_sat_lo", ctr_at(32'h40), 2'b00);
        // Same-index read and update: prediction uses the old counter.
        misb(32'h40);
        cycle(1'b1, BeqP8, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
        check_out("t4_rw_same", 32'h44, 1'b1, 1'b0);
        check("t4_rw_ctr", ctr_at(32'h40), 2'b01);

        // T5 misbranch beats ask; training still applies
        cycle(1'b1, JalP16, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1);
        check_out("t5_misb", 32'h200, 1'b1, 1'b0);
        check("t5_train", ctr_at(32'h80), 2'b10);

        // T6 rdy freeze, then asynchronous reset
        ask(JalP16);
        check_out("t6_pre", 32'h210, 1'b1, 1'b1);
        rdy = 1'b0;
        cycle(1'b1, JalP16, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check_out("t6_frozen", 32'h210, 1'b1, 1'b1);
        check("t6_ctr_frozen", ctr_at(32'h10), 2'b11);
        rdy = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check_out("t6_async_rst", 32'h0, 1'b0, 1'b0);
        check("t6_ctr_rst", ctr_at(32'h10), 2'b01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ask(JalP16);
        check_out("t6_after_rst", 32'h10, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
